excp_csr_trap: RTL and testbench
================================

Name: excp_csr_trap

Overview:
- Machine-mode trap CSR file that sits directly downstream of the exception/interrupt top.
- Consumes the commit bundle `cmt_*` plus mret, and holds mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcycle, minstret and mcountinhibit.
- Drives `status_mie_r`, `mtie_r`, `msie_r`, `meie_r` and `csr_mtvec_r` back into the exception top, and `csr_mepc_r` to the PC unit for mret redirect.
- Serves the ALU CSR-instruction read/write port.

Parameters:
- XLEN, 32, CSR data width.
- PC_SIZE, 32, PC/epc width.
- MTVEC_RST, 32'h0000_0080, mtvec reset value (bits[1:0] must be 0).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cmt_epc_ena  in  1  trap commit: load mepc.
- cmt_epc  in  PC_SIZE  trapping PC.
- cmt_cause_ena  in  1  load mcause.
- cmt_cause  in  XLEN  cause (bit31 = interrupt).
- cmt_badaddr_ena  in  1  load mtval.
- cmt_badaddr  in  XLEN  bad address or instruction.
- cmt_status_ena  in  1  trap entry mstatus update.
- cmt_mret_ena  in  1  mret committed.
- cmt_instret  in  1  one instruction retired this cycle.
- ext_irq, sft_irq, tmr_irq  in  1 each  raw pending levels for mip.
- csr_ena  in  1  CSR access valid.
- csr_wr_en  in  1  write request.
- csr_rd_en  in  1  read request.
- csr_idx  in  12  CSR address.
- csr_wdata  in  XLEN  final write value (RMW resolved by ALU).
- csr_rdata  out  XLEN  read data.
- csr_ilegl  out  1  illegal CSR access.
- status_mie_r, mtie_r, msie_r, meie_r  out  1 each  enable bits.
- csr_mtvec_r  out  XLEN  trap vector.
- csr_mepc_r  out  PC_SIZE  return PC.

Behaviour:
Reset (asynchronous, active-high):
- MIE = 0, MPIE = 0, MPP = 2'b11.
- mie = 0, mepc = 0, mcause = 0, mtval = 0, mscratch = 0.
- mtvec = MTVEC_RST.
- mcycle = 0, minstret = 0, mcountinhibit = 0.
- mip sampling flops = 0.
- All outputs derive from these registers, so on reset `csr_rdata` = 0 and `csr_ilegl` = 0.
- Reset asserted mid-access discards the write.

Read path:
- Combinational, zero latency, from current register state.
- `csr_rdata` = 0 when `csr_ena` & `csr_rd_en` is low.

Write path:
- Takes effect on the next rising clk when `csr_ena` & `csr_wr_en` & ~`csr_ilegl`.

Address map:
- 0x300 mstatus: only MIE[3], MPIE[7], MPP[12:11] are implemented; MPP is hardwired to 11 and other bits read 0.
- 0x304 mie: bits 3, 7, 11 only.
- 0x305 mtvec: bits[1:0] forced to 0 (direct mode only).
- 0x340 mscratch.
- 0x341 mepc: bit0 forced to 0.
- 0x342 mcause.
- 0x343 mtval.
- 0x344 mip: read-only; MSIP[3], MTIP[7], MEIP[11] come from a 1-flop registered sample of the irq inputs.
- 0x320 mcountinhibit: bits 0 and 2 only.
- 0xB00 / 0xB80 mcycle low/high.
- 0xB02 / 0xB82 minstret low/high.

Illegal access (`csr_ilegl` = 1, combinational, no state change):
- `csr_ena` with an unmapped address.
- A write to mip.

Trap entry:
- On the clk edge with `cmt_status_ena`: MPIE <= MIE, MIE <= 0.

mret:
- On the clk edge with `cmt_mret_ena`: MIE <= MPIE, MPIE <= 1.

Trap-field loads:
- `cmt_epc_ena` loads mepc with {cmt_epc[31:1], 1'b0}.
- `cmt_cause_ena` loads mcause.
- `cmt_badaddr_ena` loads mtval.

Priority when events coincide in one cycle:
- Trap commit beats a CSR write to the same register; the CSR write to that register is dropped.
- Trap beats mret; mret is ignored.
- mret beats a CSR write to mstatus.

Counters (64-bit):
- mcycle increments every clk unless mcountinhibit[0].
- minstret increments when `cmt_instret` & ~mcountinhibit[2].
- Both wrap from 2^64-1 to 0.
- A CSR write to a half replaces that half for the cycle; the increment is suppressed that cycle for the whole counter.
- Carry from low to high happens in the same cycle.

Decomposition:
- Shared package/defines: CSR address constants, mstatus bit positions, MTVEC_RST default, cause encodings.
- One natural sub-module: excp_csr_cnt64, a 64-bit counter with inhibit, increment enable, and half-word write ports; instantiated twice (mcycle, minstret).

Test Plan:
1. Reset, then read 0x305 -> `csr_rdata` = 32'h0000_0080; read 0x300 -> 32'h0000_1800.
2. Write mstatus 0x8, then pulse `cmt_status_ena` + `cmt_epc_ena` (epc 32'h0000_1235) + `cmt_cause_ena` (32'h8000_000B):
   - `status_mie_r` 1 -> 0, mstatus reads 32'h0000_1880;
   - mepc reads 32'h0000_1234, mcause reads 32'h8000_000B.
3. Then pulse `cmt_mret_ena` -> `status_mie_r` = 1, mstatus reads 32'h0000_1888; `csr_mepc_r` = 32'h0000_1234.
4. Same-cycle CSR write mepc = 32'hDEAD_BEEF and `cmt_epc_ena` epc = 32'h40 -> mepc reads 32'h0000_0040.
5. Write 0x344 or read 0x7FF -> `csr_ilegl` = 1, no register changes.
6. Counters:
   - Write mcycle low = 32'hFFFF_FFFF, high = 0; next cycle read 0xB80 -> 1.
   - Set mcountinhibit = 5 -> mcycle is frozen across 10 cycles, and minstret is unchanged despite `cmt_instret` pulses.

Source files
------------

// File: rtl/excp_csr_trap_pkg.sv
// rtl/excp_csr_trap_pkg.sv - shared CSR addresses, bit positions and cause codes for the trap CSR file
package excp_csr_trap_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS  = 12'h300,
    CSR_MIE      = 12'h304,
    CSR_MTVEC    = 12'h305,
    CSR_MCOUNTIH = 12'h320,
    CSR_MSCRATCH = 12'h340,
    CSR_MEPC     = 12'h341,
    CSR_MCAUSE   = 12'h342,
    CSR_MTVAL    = 12'h343,
    CSR_MIP      = 12'h344,
    CSR_MCYCLE   = 12'hB00,
    CSR_MINSTRET = 12'hB02,
    CSR_MCYCLEH  = 12'hB80,
    CSR_MINSTRTH = 12'hB82
  } csr_addr_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie and mip share the same bit layout
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam int CINH_CY = 0;
  localparam int CINH_IR = 2;

  localparam logic [31:0] MTVEC_RST_DFLT = 32'h0000_0080;

  localparam logic [31:0] CAUSE_INT_FLAG   = 32'h8000_0000;
  localparam logic [31:0] CAUSE_M_SFT_IRQ  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_M_TMR_IRQ  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_EXT_IRQ  = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL_IR = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'h0000_000B;

endpackage

// File: rtl/excp_csr_cnt64.sv
// rtl/excp_csr_cnt64.sv - 64-bit machine counter with inhibit, increment enable and half-word writes
module excp_csr_cnt64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inhibit,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  // any software write to either half freezes the whole counter for that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo | wr_hi) begin
      if (wr_lo) cnt[31:0]  <= wdata;
      if (wr_hi) cnt[63:32] <= wdata;
    end else if (inc_en & ~inhibit) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/excp_csr_trap.sv
// rtl/excp_csr_trap.sv - machine-mode trap CSR file fed by the exception commit bundle
module excp_csr_trap
  import excp_csr_trap_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              PC_SIZE   = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = XLEN'(MTVEC_RST_DFLT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_epc_ena,
  input  logic [PC_SIZE-1:0] cmt_epc,
  input  logic               cmt_cause_ena,
  input  logic [XLEN-1:0]    cmt_cause,
  input  logic               cmt_badaddr_ena,
  input  logic [XLEN-1:0]    cmt_badaddr,
  input  logic               cmt_status_ena,
  input  logic               cmt_mret_ena,
  input  logic               cmt_instret,
  input  logic               ext_irq,
  input  logic               sft_irq,
  input  logic               tmr_irq,
  input  logic               csr_ena,
  input  logic               csr_wr_en,
  input  logic               csr_rd_en,
  input  logic [11:0]        csr_idx,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_ilegl,
  output logic               status_mie_r,
  output logic               mtie_r,
  output logic               msie_r,
  output logic               meie_r,
  output logic [XLEN-1:0]    csr_mtvec_r,
  output logic [PC_SIZE-1:0] csr_mepc_r
);

  logic              status_mpie_r;
  logic [XLEN-1:0]   mscratch_r;
  logic [XLEN-1:0]   mcause_r;
  logic [XLEN-1:0]   mtval_r;
  logic              mip_msi_r, mip_mti_r, mip_mei_r;
  logic              cinh_cy_r, cinh_ir_r;
  logic [63:0]       mcycle, minstret;

  logic [XLEN-1:0]   mstatus_val, mie_val, mip_val, mcinh_val;
  logic [XLEN-1:0]   rd_mux;
  logic              addr_hit;
  logic              csr_wr;

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = status_mie_r;
    mstatus_val[MSTATUS_MPIE] = status_mpie_r;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_val = '0;
    mie_val[IRQ_MSI] = msie_r;
    mie_val[IRQ_MTI] = mtie_r;
    mie_val[IRQ_MEI] = meie_r;
    mip_val = '0;
    mip_val[IRQ_MSI] = mip_msi_r;
    mip_val[IRQ_MTI] = mip_mti_r;
    mip_val[IRQ_MEI] = mip_mei_r;
    mcinh_val = '0;
    mcinh_val[CINH_CY] = cinh_cy_r;
    mcinh_val[CINH_IR] = cinh_ir_r;
  end

  always_comb begin
    addr_hit = 1'b1;
    rd_mux   = '0;
    case (csr_idx)
      CSR_MSTATUS:  rd_mux = mstatus_val;
      CSR_MIE:      rd_mux = mie_val;
      CSR_MTVEC:    rd_mux = csr_mtvec_r;
      CSR_MCOUNTIH: rd_mux = mcinh_val;
      CSR_MSCRATCH: rd_mux = mscratch_r;
      CSR_MEPC:     rd_mux = XLEN'(csr_mepc_r);
      CSR_MCAUSE:   rd_mux = mcause_r;
      CSR_MTVAL:    rd_mux = mtval_r;
      CSR_MIP:      rd_mux = mip_val;
      CSR_MCYCLE:   rd_mux = XLEN'(mcycle[31:0]);
      CSR_MCYCLEH:  rd_mux = XLEN'(mcycle[63:32]);
      CSR_MINSTRET: rd_mux = XLEN'(minstret[31:0]);
      CSR_MINSTRTH: rd_mux = XLEN'(minstret[63:32]);
      default:      addr_hit = 1'b0;
    endcase
  end

  assign csr_ilegl = csr_ena & (~addr_hit | (csr_wr_en & (csr_idx == CSR_MIP)));
  assign csr_rdata = (csr_ena & csr_rd_en) ? rd_mux : '0;
  assign csr_wr    = csr_ena & csr_wr_en & ~csr_ilegl;

  // trap entry outranks mret, and both outrank a software write to mstatus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_mie_r  <= 1'b0;
      status_mpie_r <= 1'b0;
    end else if (cmt_status_ena) begin
      status_mpie_r <= status_mie_r;
      status_mie_r  <= 1'b0;
    end else if (cmt_mret_ena) begin
      status_mie_r  <= status_mpie_r;
      status_mpie_r <= 1'b1;
    end else if (csr_wr && csr_idx == CSR_MSTATUS) begin
      status_mie_r  <= csr_wdata[MSTATUS_MIE];
      status_mpie_r <= csr_wdata[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msie_r      <= 1'b0;
      mtie_r      <= 1'b0;
      meie_r      <= 1'b0;
      csr_mtvec_r <= MTVEC_RST;
      mscratch_r  <= '0;
      cinh_cy_r   <= 1'b0;
      cinh_ir_r   <= 1'b0;
    end else if (csr_wr) begin
      case (csr_idx)
        CSR_MIE: begin
          msie_r <= csr_wdata[IRQ_MSI];
          mtie_r <= csr_wdata[IRQ_MTI];
          meie_r <= csr_wdata[IRQ_MEI];
        end
        CSR_MTVEC:    csr_mtvec_r <= csr_wdata & ~XLEN'(3);
        CSR_MSCRATCH: mscratch_r  <= csr_wdata;
        CSR_MCOUNTIH: begin
          cinh_cy_r <= csr_wdata[CINH_CY];
          cinh_ir_r <= csr_wdata[CINH_IR];
        end
        default: ;
      endcase
    end
  end

  // commit-side loads win over a same-cycle software write to the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_mepc_r <= '0;
      mcause_r   <= '0;
      mtval_r    <= '0;
    end else begin
      if (cmt_epc_ena)
        csr_mepc_r <= cmt_epc & ~PC_SIZE'(1);
      else if (csr_wr && csr_idx == CSR_MEPC)
        csr_mepc_r <= PC_SIZE'(csr_wdata) & ~PC_SIZE'(1);
      if (cmt_cause_ena)
        mcause_r <= cmt_cause;
      else if (csr_wr && csr_idx == CSR_MCAUSE)
        mcause_r <= csr_wdata;
      if (cmt_badaddr_ena)
        mtval_r <= cmt_badaddr;
      else if (csr_wr && csr_idx == CSR_MTVAL)
        mtval_r <= csr_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip_msi_r <= 1'b0;
      mip_mti_r <= 1'b0;
      mip_mei_r <= 1'b0;
    end else begin
      mip_msi_r <= sft_irq;
      mip_mti_r <= tmr_irq;
      mip_mei_r <= ext_irq;
    end
  end

  excp_csr_cnt64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inhibit (cinh_cy_r),
    .inc_en  (1'b1),
    .wr_lo   (csr_wr && csr_idx == CSR_MCYCLE),
    .wr_hi   (csr_wr && csr_idx == CSR_MCYCLEH),
    .wdata   (csr_wdata[31:0]),
    .cnt     (mcycle)
  );

  excp_csr_cnt64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inhibit (cinh_ir_r),
    .inc_en  (cmt_instret),
    .wr_lo   (csr_wr && csr_idx == CSR_MINSTRET),
    .wr_hi   (csr_wr && csr_idx == CSR_MINSTRTH),
    .wdata   (csr_wdata[31:0]),
    .cnt     (minstret)
  );

endmodule

// File: tb/tb_excp_csr_trap.sv
// tb/tb_excp_csr_trap.sv - directed and randomized checks of excp_csr_trap against a behavioural model
module tb_excp_csr_trap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmt_epc_ena = 0, cmt_cause_ena = 0, cmt_badaddr_ena = 0;
  logic        cmt_status_ena = 0, cmt_mret_ena = 0, cmt_instret = 0;
  logic [31:0] cmt_epc = 0, cmt_cause = 0, cmt_badaddr = 0;
  logic        ext_irq = 0, sft_irq = 0, tmr_irq = 0;
  logic        csr_ena = 0, csr_wr_en = 0, csr_rd_en = 0;
  logic [11:0] csr_idx = 0;
  logic [31:0] csr_wdata = 0;
  logic [31:0] csr_rdata;
  logic        csr_ilegl;
  logic        status_mie_r, mtie_r, msie_r, meie_r;
  logic [31:0] csr_mtvec_r, csr_mepc_r;

  int checks = 0;
  int failures = 0;
  logic [31:0] obs_rdata;
  logic        obs_ilegl;

  // reference state: architectural view of each CSR
  bit          m_mie, m_mpie;
  logic [31:0] m_ie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cinh, m_mip;
  logic [63:0] m_cyc, m_ins;

  excp_csr_trap dut (
    .clk(clk), .rst(rst),
    .cmt_epc_ena(cmt_epc_ena), .cmt_epc(cmt_epc),
    .cmt_cause_ena(cmt_cause_ena), .cmt_cause(cmt_cause),
    .cmt_badaddr_ena(cmt_badaddr_ena), .cmt_badaddr(cmt_badaddr),
    .cmt_status_ena(cmt_status_ena), .cmt_mret_ena(cmt_mret_ena),
    .cmt_instret(cmt_instret),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ilegl(csr_ilegl),
    .status_mie_r(status_mie_r), .mtie_r(mtie_r), .msie_r(msie_r), .meie_r(meie_r),
    .csr_mtvec_r(csr_mtvec_r), .csr_mepc_r(csr_mepc_r)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_ie = 0; m_mtvec = 32'h80; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_cinh = 0; m_mip = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] idx, output bit hit);
    hit = 1;
    case (idx)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_mtvec;
      12'h320: return m_cinh;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: begin hit = 0; return 32'h0; end
    endcase
  endfunction

  task automatic model_step(input bit wr);
    bit w_cyc, w_ins;
    if (cmt_status_ena) begin m_mpie = m_mie; m_mie = 0; end
    else if (cmt_mret_ena) begin m_mie = m_mpie; m_mpie = 1; end
    else if (wr && csr_idx == 12'h300) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
    if (cmt_epc_ena) m_mepc = cmt_epc & ~32'h1;
    else if (wr && csr_idx == 12'h341) m_mepc = csr_wdata & ~32'h1;
    if (cmt_cause_ena) m_mcause = cmt_cause;
    else if (wr && csr_idx == 12'h342) m_mcause = csr_wdata;
    if (cmt_badaddr_ena) m_mtval = cmt_badaddr;
    else if (wr && csr_idx == 12'h343) m_mtval = csr_wdata;
    if (wr && csr_idx == 12'h304) m_ie = csr_wdata & 32'h888;
    if (wr && csr_idx == 12'h305) m_mtvec = csr_wdata & ~32'h3;
    if (wr && csr_idx == 12'h340) m_mscratch = csr_wdata;
    w_cyc = wr && (csr_idx == 12'hB00 || csr_idx == 12'hB80);
    w_ins = wr && (csr_idx == 12'hB02 || csr_idx == 12'hB82);
    if (w_cyc) begin
      if (csr_idx == 12'hB00) m_cyc[31:0] = csr_wdata; else m_cyc[63:32] = csr_wdata;
    end else if (!m_cinh[0]) m_cyc = m_cyc + 64'd1;
    if (w_ins) begin
      if (csr_idx == 12'hB02) m_ins[31:0] = csr_wdata; else m_ins[63:32] = csr_wdata;
    end else if (cmt_instret && !m_cinh[2]) m_ins = m_ins + 64'd1;
    if (wr && csr_idx == 12'h320) m_cinh = csr_wdata & 32'h5;
    m_mip = (32'(ext_irq) << 11) | (32'(tmr_irq) << 7) | (32'(sft_irq) << 3);
  endtask

  task automatic chk_outputs();
    chk("status_mie_r", {31'b0, status_mie_r}, {31'b0, m_mie});
    chk("msie_r", {31'b0, msie_r}, {31'b0, m_ie[3]});
    chk("mtie_r", {31'b0, mtie_r}, {31'b0, m_ie[7]});
    chk("meie_r", {31'b0, meie_r}, {31'b0, m_ie[11]});
    chk("csr_mtvec_r", csr_mtvec_r, m_mtvec);
    chk("csr_mepc_r", csr_mepc_r, m_mepc);
  endtask

  // inputs are set by the caller just after a rising edge; this samples at the falling edge
  task automatic do_cycle();
    logic [31:0] er;
    bit hit, eill, wr;
    @(negedge clk);
    er   = model_rd(csr_idx, hit);
    eill = csr_ena && (!hit || (csr_wr_en && csr_idx == 12'h344));
    chk("csr_ilegl", {31'b0, csr_ilegl}, {31'b0, eill});
    chk("csr_rdata", csr_rdata, (csr_ena && csr_rd_en) ? er : 32'h0);
    obs_rdata = csr_rdata;
    obs_ilegl = csr_ilegl;
    wr = csr_ena && csr_wr_en && !eill;
    @(posedge clk);
    model_step(wr);
    #1;
    chk_outputs();
  endtask

  task automatic clear_inputs();
    cmt_epc_ena = 0; cmt_cause_ena = 0; cmt_badaddr_ena = 0;
    cmt_status_ena = 0; cmt_mret_ena = 0; cmt_instret = 0;
    csr_ena = 0; csr_wr_en = 0; csr_rd_en = 0; csr_idx = 0; csr_wdata = 0;
  endtask

  task automatic csr_op(input bit w, input bit r, input logic [11:0] idx, input logic [31:0] d);
    csr_ena = 1; csr_wr_en = w; csr_rd_en = r; csr_idx = idx; csr_wdata = d;
    do_cycle();
    clear_inputs();
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    csr_op(0, 1, idx, 32'h0);
    chk(tag, obs_rdata, exp);
  endtask

  initial begin
    logic [11:0] addrs [15];
    logic [31:0] frozen_cyc, frozen_ins;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7FF, 12'h301};

    // reset state
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_ilegl", {31'b0, csr_ilegl}, 32'h0);
    chk_outputs();
    rst = 0;

    rd_expect("rst_mtvec", 12'h305, 32'h0000_0080);
    rd_expect("rst_mstatus", 12'h300, 32'h0000_1800);

    // trap entry with epc/cause loads
    csr_op(1, 0, 12'h300, 32'h8);
    chk("mie_set", {31'b0, status_mie_r}, 32'h1);
    cmt_status_ena = 1; cmt_epc_ena = 1; cmt_epc = 32'h0000_1235;
    cmt_cause_ena = 1; cmt_cause = 32'h8000_000B;
    do_cycle();
    clear_inputs();
    chk("trap_mie", {31'b0, status_mie_r}, 32'h0);
    rd_expect("trap_mstatus", 12'h300, 32'h0000_1880);
    rd_expect("trap_mepc", 12'h341, 32'h0000_1234);
    rd_expect("trap_mcause", 12'h342, 32'h8000_000B);

    // mret
    cmt_mret_ena = 1;
    do_cycle();
    clear_inputs();
    chk("mret_mie", {31'b0, status_mie_r}, 32'h1);
    chk("mret_mepc_r", csr_mepc_r, 32'h0000_1234);
    rd_expect("mret_mstatus", 12'h300, 32'h0000_1888);

    // commit beats same-cycle CSR write to mepc
    cmt_epc_ena = 1; cmt_epc = 32'h40;
    csr_op(1, 0, 12'h341, 32'hDEAD_BEEF);
    rd_expect("epc_prio", 12'h341, 32'h0000_0040);

    // trap beats mret and CSR write; mret beats CSR write
    cmt_status_ena = 1; cmt_mret_ena = 1;
    csr_op(1, 0, 12'h300, 32'h88);
    chk("trap_over_mret", {31'b0, status_mie_r}, 32'h0);
    cmt_mret_ena = 1;
    csr_op(1, 0, 12'h300, 32'h0);
    chk("mret_over_wr", {31'b0, status_mie_r}, 32'h1);

    // illegal accesses
    sft_irq = 1; tmr_irq = 1;
    csr_op(1, 0, 12'h344, 32'hFFFF_FFFF);
    chk("ilegl_mip_wr", {31'b0, obs_ilegl}, 32'h1);
    rd_expect("mip_sample", 12'h344, 32'h0000_0088);
    chk("ilegl_mip_rd", {31'b0, obs_ilegl}, 32'h0);
    csr_op(1, 1, 12'h7FF, 32'h1234_5678);
    chk("ilegl_unmapped", {31'b0, obs_ilegl}, 32'h1);
    sft_irq = 0; tmr_irq = 0;

    // counter carry
    csr_op(1, 0, 12'hB00, 32'hFFFF_FFFF);
    csr_op(1, 0, 12'hB80, 32'h0);
    rd_expect("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rd_expect("mcycle_carry", 12'hB80, 32'h1);

    // counter inhibit
    csr_op(1, 0, 12'h320, 32'hFFFF_FFFF);
    rd_expect("mcinh", 12'h320, 32'h5);
    frozen_cyc = m_cyc[31:0];
    frozen_ins = m_ins[31:0];
    for (int i = 0; i < 10; i++) begin
      cmt_instret = 1;
      do_cycle();
    end
    clear_inputs();
    rd_expect("mcycle_frozen", 12'hB00, frozen_cyc);
    rd_expect("minstret_frozen", 12'hB02, frozen_ins);
    csr_op(1, 0, 12'h320, 32'h0);

    // reset during a pending write drops it
    csr_op(1, 0, 12'h340, 32'hAAAA_5555);
    csr_ena = 1; csr_wr_en = 1; csr_idx = 12'h340; csr_wdata = 32'h1111_2222;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    clear_inputs();
    rd_expect("rst_mid_mscratch", 12'h340, 32'h0);
    rd_expect("rst_mid_mstatus", 12'h300, 32'h0000_1800);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      csr_ena   = ($urandom_range(0, 9) < 7);
      csr_wr_en = $urandom_range(0, 1);
      csr_rd_en = $urandom_range(0, 1);
      csr_idx   = addrs[$urandom_range(0, 14)];
      csr_wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cmt_status_ena  = ($urandom_range(0, 9) == 0);
      cmt_mret_ena    = ($urandom_range(0, 7) == 0);
      cmt_epc_ena     = ($urandom_range(0, 9) == 0);
      cmt_cause_ena   = ($urandom_range(0, 9) == 0);
      cmt_badaddr_ena = ($urandom_range(0, 9) == 0);
      cmt_epc = $urandom; cmt_cause = $urandom; cmt_badaddr = $urandom;
      cmt_instret = $urandom_range(0, 1);
      ext_irq = $urandom_range(0, 1);
      sft_irq = $urandom_range(0, 1);
      tmr_irq = $urandom_range(0, 1);
      do_cycle();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
